dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-memory stage directly downstream of the multi-cycle CPU core.
- Consumes the core's data_addr, w_data, dmem_r, dmem_w and store_format_signal outputs; returns dmem_data.
- Owns a word-wide synchronous single-port RAM. Performs read-modify-write (RMW) for byte and halfword stores.
- Returns byte/halfword loads right-aligned and zero-filled; the core performs any sign extension.
- Uses a 4-phase ready handshake so the core's controller can hold its requests for as many states as it needs.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address of RAM word 0.
- DEPTH_LOG2, 11, log2 of RAM depth in 32-bit words (default 8 KB).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dmem_r  in  1  load request, level, held until ready.
- dmem_w  in  1  store request, level, held until ready.
- addr  in  32  byte address (core data_addr).
- wdata  in  32  store data; sub-word data is taken from the low bits.
- store_format  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
- rdata  out  32  load result (core dmem_data).
- ready  out  1  access complete.
- err  out  1  access rejected, qualified by ready.

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE; rdata=0, ready=0, err=0; RAM contents are not cleared.
  - Reset mid-operation aborts the access with no ready pulse.
  - A RAM write already performed on an earlier edge stays committed.
- States: IDLE, LD_WAIT, RMW_RD, ST_WR, DONE.
- IDLE, on (dmem_r | dmem_w) = cycle 0:
  - Capture addr, wdata, store_format and the direction into registers.
  - Compute off = addr - BASE_ADDR.
  - Error if any of these hold: off >= 4*2^DEPTH_LOG2; word with addr[1:0]!=0; halfword with addr[0]!=0; format 11; dmem_r & dmem_w both high.
  - Error → DONE with err=1, rdata=0, no RAM access.
  - Otherwise issue the RAM read of word off[DEPTH_LOG2+1:2] when needed. Load → LD_WAIT; word store → ST_WR; sub-word store → RMW_RD.
- LD_WAIT (cycle 1):
  - Select from the RAM output: word = full word; halfword = {16'b0, lane addr[1]}; byte = {24'b0, lane addr[1:0]}.
  - Register the result into rdata → DONE.
- Lanes are little-endian: byte k is bits [8k+7:8k]; halfword h is bits [16h+15:16h].
- RMW_RD (cycle 1): merge wdata[7:0] or wdata[15:0] into the selected lane of the RAM output; other lanes are preserved. Hold the merged word → ST_WR.
- ST_WR: write the captured word (word store) or merged word (sub-word store) → DONE.
- Latency from cycle 0 to the first ready-high cycle: load 2, word store 2, sub-word store 3, error 1.
- DONE:
  - ready=1; rdata holds the load result (store and error: 0); err is valid.
  - Stays in DONE while dmem_r | dmem_w; when both are low → IDLE with ready=0, err=0.
  - A new request is sampled only in IDLE, so a held request never re-triggers.
- Changing addr, wdata or format while busy has no effect, since the captured values are used.
- Only ST_WR writes the RAM; at most one RAM write per access.

Decomposition:
- Package dmem_pkg:
  - format constants FMT_WORD=2'b00, FMT_HALF=2'b01, FMT_BYTE=2'b10;
  - state encoding;
  - the lane-select and merge functions, shared with the bench model.
- Sub-module dmem_sram: single-port synchronous RAM, 2^DEPTH_LOG2 x 32, registered read data, write enable, no reset on the array. Behavioural array, synthesizable as block RAM.
- The FSM, capture registers, checks, lane logic and handshake live in dmem_bridge.

Test Plan:
- Word store then load at 0x10010008:
  - store 0xDEADBEEF → ready 2 cycles after the request;
  - load from the same address → rdata=0xDEADBEEF, 2-cycle latency, err=0.
- Byte RMW at 0x10010009:
  - word 0x11223344 at 0x10010008;
  - store byte wdata=0x000000AA → the word reads back 0x1122AA44, ready 3 cycles after the request;
  - byte load at 0x10010009 → rdata=0x000000AA.
- Halfword at 0x1001000A:
  - store 0xBEEF into 0x11223344 → word 0xBEEF3344;
  - halfword load at 0x1001000A → rdata=0x0000BEEF.
- Errors, each → ready with err=1, rdata=0, RAM unchanged, 1-cycle latency:
  - word load at 0x10010002;
  - halfword store at 0x10010001;
  - byte load at 0x10012000 (off=8192);
  - format 11;
  - dmem_r & dmem_w together.
- Handshake: hold dmem_w for 6 cycles after ready → exactly one RAM write, ready held high; drop the request → ready low next cycle; a new load is accepted the following cycle.
- Reset mid-operation: assert rst during RMW_RD of a byte store → no ready pulse, word unchanged, state IDLE; a subsequent load returns the original data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: access formats, FSM encoding,
// and the little-endian lane select/merge helpers.
package dmem_pkg;

   localparam logic [1:0] FMT_WORD = 2'b00;
   localparam logic [1:0] FMT_HALF = 2'b01;
   localparam logic [1:0] FMT_BYTE = 2'b10;
   localparam logic [1:0] FMT_RSVD = 2'b11;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LD_WAIT = 3'd1;
   localparam logic [2:0] ST_RMW_RD  = 3'd2;
   localparam logic [2:0] ST_ST_WR   = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   typedef struct packed {
      logic [1:0] fmt;
      logic [1:0] lo;
   } req_t;

   // Right-aligned, zero-filled sub-word extraction; lane k lives at bits [8k+7:8k].
   function automatic logic [31:0] lane_select(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  fmt);
      logic [4:0]  sh;
      logic [31:0] mask;
      sh   = {lo, 3'b000};
      mask = (fmt == FMT_HALF) ? 32'h0000_FFFF :
             (fmt == FMT_BYTE) ? 32'h0000_00FF : 32'hFFFF_FFFF;
      lane_select = (word >> sh) & mask;
   endfunction

   // Replace the addressed lane of word with the low bits of wdata.
   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  fmt);
      logic [4:0]  sh;
      logic [31:0] mask;
      sh = {lo, 3'b000};
      if (fmt == FMT_HALF || fmt == FMT_BYTE) begin
         mask       = ((fmt == FMT_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
         lane_merge = (word & ~mask) | ((wdata << sh) & mask);
      end else begin
         lane_merge = wdata;
      end
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous RAM, 2^AW x 32, registered read data, no array reset.
module dmem_sram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          re_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [2**AW];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory stage: decodes core load/store requests, does read-modify-write
// for sub-word stores and answers over a 4-phase ready handshake.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
   parameter int          DEPTH_LOG2 = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_r,
   input  logic        dmem_w,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  store_format,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic [2:0]  dbg_state
);

   localparam logic [31:0] RAM_BYTES = 32'd4 << DEPTH_LOG2;

   logic [2:0]            state_q, state_d;
   req_t                  req_q, req_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [31:0]           wr_word_q, wr_word_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [31:0]           off;
   logic                  req;
   logic                  bad;
   logic                  ram_re;
   logic                  ram_we;
   logic [DEPTH_LOG2-1:0] ram_addr;
   logic [31:0]           ram_rdata;

   assign off = addr - BASE_ADDR;
   assign req = dmem_r | dmem_w;
   // Addresses below BASE_ADDR wrap to huge offsets and fail the range check too.
   assign bad = (off >= RAM_BYTES)
              | ((store_format == FMT_WORD) && (addr[1:0] != 2'b00))
              | ((store_format == FMT_HALF) && addr[0])
              | (store_format == FMT_RSVD)
              | (dmem_r & dmem_w);

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      idx_d     = idx_q;
      wr_word_d = wr_word_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      ram_re    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               req_d     = '{fmt: store_format, lo: addr[1:0]};
               idx_d     = off[DEPTH_LOG2+1:2];
               wr_word_d = wdata;
               rdata_d   = 32'h0;
               err_d     = bad;
               if (bad) begin
                  state_d = ST_DONE;
               end else if (dmem_r) begin
                  ram_re  = 1'b1;
                  state_d = ST_LD_WAIT;
               end else if (store_format == FMT_WORD) begin
                  state_d = ST_ST_WR;
               end else begin
                  ram_re  = 1'b1;
                  state_d = ST_RMW_RD;
               end
            end
         end
         ST_LD_WAIT: begin
            rdata_d = lane_select(ram_rdata, req_q.lo, req_q.fmt);
            state_d = ST_DONE;
         end
         ST_RMW_RD: begin
            wr_word_d = lane_merge(ram_rdata, wr_word_q, req_q.lo, req_q.fmt);
            state_d   = ST_ST_WR;
         end
         ST_ST_WR: state_d = ST_DONE;
         ST_DONE: begin
            if (!req) begin
               rdata_d = 32'h0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The read in IDLE must use the live address; later phases use the captured index.
   assign ram_addr = (state_q == ST_IDLE) ? off[DEPTH_LOG2+1:2] : idx_q;
   assign ram_we   = (state_q == ST_ST_WR) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         idx_q     <= '0;
         wr_word_q <= 32'h0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         idx_q     <= idx_d;
         wr_word_q <= wr_word_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   dmem_sram #(.AW(DEPTH_LOG2)) u_sram (
      .clk     (clk),
      .re_i    (ram_re),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (wr_word_q),
      .rdata_o (ram_rdata)
   );

   assign rdata     = rdata_q;
   assign err       = err_q;
   assign ready     = (state_q == ST_DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: drivers push expected responses, a monitor
// pops them on each rising ready and checks data, error flag and latency.
module tb_dmem_bridge;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dmem_r, dmem_w;
   logic [31:0] addr, wdata;
   logic [1:0]  store_format;
   logic [31:0] rdata;
   logic        ready, err;
   logic [2:0]  dbg_state;

   int tests_run = 0;
   int fail_cnt  = 0;
   int cyc       = 0;
   int wr_cnt    = 0;

   // {err, rdata[31:0], latency[7:0], issue_cycle[15:0]}
   logic [56:0] exp_q[$];
   logic        ready_prev = 1'b0;

   dmem_bridge #(.BASE_ADDR(32'h1001_0000), .DEPTH_LOG2(11)) dut (
      .clk          (clk),
      .rst          (rst),
      .dmem_r       (dmem_r),
      .dmem_w       (dmem_w),
      .addr         (addr),
      .wdata        (wdata),
      .store_format (store_format),
      .rdata        (rdata),
      .ready        (ready),
      .err          (err),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      wr_cnt <= wr_cnt + (dut.ram_we ? 1 : 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected response per rising edge of ready.
   always @(negedge clk) begin
      logic [56:0] e;
      if (rst) begin
         ready_prev <= 1'b0;
      end else begin
         if (ready && !ready_prev) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               fail_cnt++;
               $display("FAIL unexpected_ready: got ready=1 rdata=%h expected no response", rdata);
            end else begin
               e = exp_q.pop_front();
               check("rdata", rdata, e[55:24]);
               check("err", {31'h0, err}, {31'h0, e[56]});
               check("latency", 32'(cyc - int'(e[15:0])), {24'h0, e[23:16]});
            end
         end
         ready_prev <= ready;
      end
   end

   // Called at a negedge; returns at the negedge where ready has dropped again.
   task automatic access(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] f,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input int hold);
      int   snap;
      logic seen;
      logic held_ok;
      snap = wr_cnt;
      exp_q.push_back({exp_err, exp_rd, 8'(lat), 16'(cyc)});
      dmem_r = r; dmem_w = w; addr = a; wdata = d; store_format = f;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = ready;
         // Captured values must win over whatever the core drives while busy.
         addr = a ^ 32'h0000_0044; wdata = ~d; store_format = ~f;
      end
      if (!seen) begin
         tests_run++;
         fail_cnt++;
         $display("FAIL ready_timeout: got no ready in 20 cycles, expected ready at latency %0d", lat);
      end
      held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!ready) held_ok = 1'b0;
      end
      if (hold > 0) check("ready_held", {31'h0, held_ok}, 32'h1);
      dmem_r = 1'b0; dmem_w = 1'b0;
      @(negedge clk);
      check("ready_drop", {31'h0, ready}, 32'h0);
      check("err_drop", {31'h0, err}, 32'h0);
      check("ram_writes", 32'(wr_cnt - snap), (w && !exp_err) ? 32'h1 : 32'h0);
   endtask

   initial begin
      int snap;
      #1000000;
      $display("FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      rst = 1'b1; dmem_r = 1'b0; dmem_w = 1'b0;
      addr = 32'h0; wdata = 32'h0; store_format = FMT_WORD;
      repeat (3) @(negedge clk);
      check("reset_ready", {31'h0, ready}, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
      rst = 1'b0;
      @(negedge clk);

      // Word store / load
      access(0, 1, 32'h1001_0008, 32'hDEAD_BEEF, FMT_WORD, 32'h0,         0, 2, 0);
      access(1, 0, 32'h1001_0008, 32'h0,         FMT_WORD, 32'hDEAD_BEEF, 0, 2, 0);
      // Byte RMW
      access(0, 1, 32'h1001_0008, 32'h1122_3344, FMT_WORD, 32'h0,         0, 2, 0);
      access(0, 1, 32'h1001_0009, 32'h0000_00AA, FMT_BYTE, 32'h0,         0, 3, 0);
      access(1, 0, 32'h1001_0008, 32'h0,         FMT_WORD, 32'h1122_AA44, 0, 2, 0);
      access(1, 0, 32'h1001_0009, 32'h0,         FMT_BYTE, 32'h0000_00AA, 0, 2, 0);
      // Halfword RMW
      access(0, 1, 32'h1001_0008, 32'h1122_3344, FMT_WORD, 32'h0,         0, 2, 0);
      access(0, 1, 32'h1001_000A, 32'h0000_BEEF, FMT_HALF, 32'h0,         0, 3, 0);
      access(1, 0, 32'h1001_0008, 32'h0,         FMT_WORD, 32'hBEEF_3344, 0, 2, 0);
      access(1, 0, 32'h1001_000A, 32'h0,         FMT_HALF, 32'h0000_BEEF, 0, 2, 0);
      access(1, 0, 32'h1001_000B, 32'h0,         FMT_BYTE, 32'h0000_00BE, 0, 2, 0);
      access(1, 0, 32'h1001_0008, 32'h0,         FMT_HALF, 32'h0000_3344, 0, 2, 0);
      // Last valid word
      access(0, 1, 32'h1001_1FFC, 32'hA5A5_5A5A, FMT_WORD, 32'h0,         0, 2, 0);
      access(1, 0, 32'h1001_1FFC, 32'h0,         FMT_WORD, 32'hA5A5_5A5A, 0, 2, 0);

      // Errors: 1-cycle latency, rdata 0, no RAM write
      access(0, 1, 32'h1001_0000, 32'hCAFE_F00D, FMT_WORD, 32'h0,         0, 2, 0);
      access(1, 0, 32'h1001_0002, 32'h0,         FMT_WORD, 32'h0,         1, 1, 0);
      access(0, 1, 32'h1001_0001, 32'h0000_5555, FMT_HALF, 32'h0,         1, 1, 0);
      access(1, 0, 32'h1001_2000, 32'h0,         FMT_BYTE, 32'h0,         1, 1, 0);
      access(0, 1, 32'h1001_0008, 32'h0000_0077, FMT_RSVD, 32'h0,         1, 1, 0);
      access(1, 1, 32'h1001_0008, 32'h1234_5678, FMT_WORD, 32'h0,         1, 1, 0);
      access(0, 1, 32'h1000_FFFC, 32'h1234_5678, FMT_WORD, 32'h0,         1, 1, 0);
      access(1, 0, 32'h1001_0000, 32'h0,         FMT_WORD, 32'hCAFE_F00D, 0, 2, 0);
      access(1, 0, 32'h1001_0008, 32'h0,         FMT_WORD, 32'hBEEF_3344, 0, 2, 0);

      // Held request: one write, ready stays high, then a back-to-back load
      access(0, 1, 32'h1001_0010, 32'h0BAD_F00D, FMT_WORD, 32'h0,         0, 2, 6);
      access(1, 0, 32'h1001_0010, 32'h0,         FMT_WORD, 32'h0BAD_F00D, 0, 2, 3);

      // Reset during RMW_RD of a byte store
      access(0, 1, 32'h1001_0014, 32'h5566_7788, FMT_WORD, 32'h0,         0, 2, 0);
      snap = wr_cnt;
      dmem_w = 1'b1; addr = 32'h1001_0015; wdata = 32'h0000_00FF; store_format = FMT_BYTE;
      @(negedge clk);
      check("rmw_state", {29'h0, dbg_state}, {29'h0, ST_RMW_RD});
      rst = 1'b1; dmem_w = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("abort_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
      check("abort_ready", {31'h0, ready}, 32'h0);
      repeat (4) @(negedge clk);
      check("abort_writes", 32'(wr_cnt - snap), 32'h0);
      access(1, 0, 32'h1001_0014, 32'h0,         FMT_WORD, 32'h5566_7788, 0, 2, 0);
      access(1, 0, 32'h1001_0015, 32'h0,         FMT_BYTE, 32'h0000_0077, 0, 2, 0);

      repeat (2) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
